// File: rtl/seq_div_16.sv
// Multi-cycle signed restoring divider with a start/done handshake.
// Truncates toward zero; the remainder carries the dividend's sign.
module seq_div_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   dsr;
    logic             sign_q;
    logic             sign_r;
    logic             div0;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Two's complement magnitude; -2^(W-1) maps to 2^(W-1) as an unsigned value.
    assign a_abs   = A[WIDTH-1] ? -A : A;
    assign b_abs   = B[WIDTH-1] ? -B : B;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign diff    = shifted - dsr;
    assign fits    = (shifted >= dsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            dvd       <= '0;
            rem       <= '0;
            dsr       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div0      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg  <= A;
                        dvd    <= a_abs;
                        rem    <= '0;
                        dsr    <= {1'b0, b_abs};
                        sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r <= A[WIDTH-1];
                        div0   <= (B == '0);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Both branches stay below 2^(W-1), so W bits hold the partial remainder.
                    rem <= fits ? WIDTH'(diff) : WIDTH'(shifted);
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div0) begin
                        quotient  <= '1;
                        remainder <= a_reg;
                    end else begin
                        quotient  <= sign_q ? -dvd : dvd;
                        remainder <= sign_r ? -rem : rem;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
